// File: rtl/rv_alu_arbiter.sv
// ---------------------------------------------------------------------------
// rv_alu_arbiter
//
// Purpose: shares one external ALU between two requesters (for example the
// execute stage and the branch/address unit). Each cycle at most one request
// is granted with round-robin priority. The granted operands drive the ALU
// combinationally, and the ALU result is registered into that requester's
// one-entry response slot.
//
// Optional feature: define RV_ALU_ARB_STATS_EN to get two saturating 16-bit
// per-requester grant counters on grant_cnt_o. When it is undefined,
// grant_cnt_o is tied to zero and no counter flops exist. The port list is the
// same in both builds.
//
// Ports:
//   clk_i, rst_i          clock and synchronous active-high reset
//   req_valid_i[1:0]      request valid, bit i = requester i
//   req_ready_o[1:0]      grant (one-hot or zero)
//   req_op_i/a/b/tag      per-requester operation, operands and tag
//   rsp_valid_o[1:0]      response slot i holds a result
//   rsp_ready_i[1:0]      requester i consumes its response
//   rsp_result/zero/tag   registered response payload per slot
//   alu_ctrl_o, alu_operand_a_o, alu_operand_b_o   drive to the shared ALU
//   alu_result_i, alu_zero_i                       result from the shared ALU
//   grant_cnt_o[1:0]      per-requester grant counters
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. req_ready_o depends combinationally on req_valid_i, so a
// requester must not make its valid depend on ready. A response slot presents
// a stable payload while rsp_valid_o is high and rsp_ready_i is low.
// ---------------------------------------------------------------------------

package rv_alu_pkg;
   typedef enum logic [3:0] {
      OP_ADD  = 4'd0,
      OP_SUB  = 4'd1,
      OP_AND  = 4'd2,
      OP_OR   = 4'd3,
      OP_XOR  = 4'd4,
      OP_SLL  = 4'd5,
      OP_SRL  = 4'd6,
      OP_SRA  = 4'd7,
      OP_SLT  = 4'd8,
      OP_SLTU = 4'd9
   } alu_operations_e;
endpackage

module rv_alu_arbiter
   import rv_alu_pkg::*;
#(
   parameter int TAG_W = 4
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic [1:0]                 req_valid_i,
   output logic [1:0]                 req_ready_o,
   input  alu_operations_e [1:0]      req_op_i,
   input  logic [1:0][31:0]           req_a_i,
   input  logic [1:0][31:0]           req_b_i,
   input  logic [1:0][TAG_W-1:0]      req_tag_i,
   output logic [1:0]                 rsp_valid_o,
   input  logic [1:0]                 rsp_ready_i,
   output logic [1:0][31:0]           rsp_result_o,
   output logic [1:0]                 rsp_zero_o,
   output logic [1:0][TAG_W-1:0]      rsp_tag_o,
   output alu_operations_e            alu_ctrl_o,
   output logic [31:0]                alu_operand_a_o,
   output logic [31:0]                alu_operand_b_o,
   input  logic [31:0]                alu_result_i,
   input  logic                       alu_zero_i,
   output logic [1:0][15:0]           grant_cnt_o
);

   // Round-robin pointer: the requester that wins when both are eligible.
   logic                  r_rr;
   logic [1:0]            r_rsp_valid;
   logic [1:0][31:0]      r_rsp_result;
   logic [1:0]            r_rsp_zero;
   logic [1:0][TAG_W-1:0] r_rsp_tag;

   logic [1:0]            w_elig;
   logic [1:0]            w_grant;
   logic                  w_gsel;

   // A full slot that drains this cycle can accept a new result on the same
   // edge, so it still counts as eligible.
   assign w_elig = req_valid_i & (~r_rsp_valid | rsp_ready_i);

   always_comb begin
      w_grant = 2'b00;
      if (!rst_i) begin
         if (w_elig == 2'b11) begin
            w_grant = 2'b01 << r_rr;
         end else begin
            w_grant = w_elig;
         end
      end
   end

   // Index of the granted requester; only meaningful when w_grant != 0.
   assign w_gsel = w_grant[1];

   assign req_ready_o = w_grant;

   // Idle drive is a fixed AND of zeros so the ALU inputs stay quiet.
   always_comb begin
      alu_ctrl_o      = OP_AND;
      alu_operand_a_o = 32'd0;
      alu_operand_b_o = 32'd0;
      if (w_grant != 2'b00) begin
         alu_ctrl_o      = alu_operations_e'(req_op_i[w_gsel]);
         alu_operand_a_o = req_a_i[w_gsel];
         alu_operand_b_o = req_b_i[w_gsel];
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_rr         <= 1'b0;
         r_rsp_valid  <= '0;
         r_rsp_result <= '0;
         r_rsp_zero   <= '0;
         r_rsp_tag    <= '0;
      end else begin
         if (w_grant != 2'b00) begin
            r_rr <= ~w_gsel;
         end
         for (int i = 0; i < 2; i++) begin
            // A new grant overrides a simultaneous drain: valid stays high
            // and the payload is replaced.
            if (w_grant[i]) begin
               r_rsp_valid[i]  <= 1'b1;
               r_rsp_result[i] <= alu_result_i;
               r_rsp_zero[i]   <= alu_zero_i;
               r_rsp_tag[i]    <= req_tag_i[i];
            end else if (rsp_ready_i[i]) begin
               r_rsp_valid[i]  <= 1'b0;
            end
         end
      end
   end

   assign rsp_valid_o  = r_rsp_valid;
   assign rsp_result_o = r_rsp_result;
   assign rsp_zero_o   = r_rsp_zero;
   assign rsp_tag_o    = r_rsp_tag;

`ifdef RV_ALU_ARB_STATS_EN
   logic [1:0][15:0] r_grant_cnt;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_grant_cnt <= '0;
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (w_grant[i] && (r_grant_cnt[i] != 16'hFFFF)) begin
               r_grant_cnt[i] <= r_grant_cnt[i] + 16'd1;
            end
         end
      end
   end

   assign grant_cnt_o = r_grant_cnt;
`else
   assign grant_cnt_o = '0;
`endif

endmodule

// File: tb/tb_rv_alu_arbiter.sv
module tb_rv_alu_arbiter;
   import rv_alu_pkg::*;

   localparam int TAG_W = 4;
   localparam int EW    = 32 + 1 + TAG_W;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic [1:0]            req_valid_i;
   logic [1:0]            req_ready_o;
   alu_operations_e [1:0] req_op_i;
   logic [1:0][31:0]      req_a_i;
   logic [1:0][31:0]      req_b_i;
   logic [1:0][TAG_W-1:0] req_tag_i;
   logic [1:0]            rsp_valid_o;
   logic [1:0]            rsp_ready_i;
   logic [1:0][31:0]      rsp_result_o;
   logic [1:0]            rsp_zero_o;
   logic [1:0][TAG_W-1:0] rsp_tag_o;
   alu_operations_e       alu_ctrl_o;
   logic [31:0]           alu_operand_a_o;
   logic [31:0]           alu_operand_b_o;
   logic [31:0]           alu_result_i;
   logic                  alu_zero_i;
   logic [1:0][15:0]      grant_cnt_o;

   rv_alu_arbiter #(.TAG_W(TAG_W)) dut (
      .clk_i           (clk),
      .rst_i           (rst),
      .req_valid_i     (req_valid_i),
      .req_ready_o     (req_ready_o),
      .req_op_i        (req_op_i),
      .req_a_i         (req_a_i),
      .req_b_i         (req_b_i),
      .req_tag_i       (req_tag_i),
      .rsp_valid_o     (rsp_valid_o),
      .rsp_ready_i     (rsp_ready_i),
      .rsp_result_o    (rsp_result_o),
      .rsp_zero_o      (rsp_zero_o),
      .rsp_tag_o       (rsp_tag_o),
      .alu_ctrl_o      (alu_ctrl_o),
      .alu_operand_a_o (alu_operand_a_o),
      .alu_operand_b_o (alu_operand_b_o),
      .alu_result_i    (alu_result_i),
      .alu_zero_i      (alu_zero_i),
      .grant_cnt_o     (grant_cnt_o)
   );

   // Reference ALU, also used as the behavioural ALU the DUT drives.
   function automatic logic [31:0] alu_f(alu_operations_e op, logic [31:0] a, logic [31:0] b);
      case (op)
         OP_ADD:  return a + b;
         OP_SUB:  return a - b;
         OP_AND:  return a & b;
         OP_OR:   return a | b;
         OP_XOR:  return a ^ b;
         OP_SLL:  return a << b[4:0];
         OP_SRL:  return a >> b[4:0];
         OP_SRA:  return $unsigned($signed(a) >>> b[4:0]);
         OP_SLT:  return {31'd0, $signed(a) < $signed(b)};
         OP_SLTU: return {31'd0, a < b};
         default: return 32'd0;
      endcase
   endfunction

   assign alu_result_i = alu_f(alu_ctrl_o, alu_operand_a_o, alu_operand_b_o);
   assign alu_zero_i   = (alu_result_i == 32'd0);

   // ---------------- vectors ----------------
   typedef struct {
      logic [1:0]       valid;
      logic [1:0]       rready;
      alu_operations_e  op0;
      logic [31:0]      a0;
      logic [31:0]      b0;
      logic [TAG_W-1:0] t0;
      alu_operations_e  op1;
      logic [31:0]      a1;
      logic [31:0]      b1;
      logic [TAG_W-1:0] t1;
      logic [1:0]       exp_grant;
   } vec_t;

   function automatic vec_t mk(logic [1:0] v, logic [1:0] r,
                               alu_operations_e o0, logic [31:0] a0, logic [31:0] b0, logic [TAG_W-1:0] t0,
                               alu_operations_e o1, logic [31:0] a1, logic [31:0] b1, logic [TAG_W-1:0] t1,
                               logic [1:0] g);
      vec_t x;
      x.valid = v; x.rready = r;
      x.op0 = o0; x.a0 = a0; x.b0 = b0; x.t0 = t0;
      x.op1 = o1; x.a1 = a1; x.b1 = b1; x.t1 = t1;
      x.exp_grant = g;
      return x;
   endfunction

   function automatic alu_operations_e rand_op();
      return alu_operations_e'(4'($urandom_range(0, 9)));
   endfunction

   // ---------------- scoreboard ----------------
   logic [EW-1:0] exp_q0[$];
   logic [EW-1:0] exp_q1[$];

   logic [1:0]            m_vld;
   logic [1:0][31:0]      m_res;
   logic [1:0]            m_zero;
   logic [1:0][TAG_W-1:0] m_tag;
   logic [1:0][15:0]      m_cnt;

   int n_vec = 0;
   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic pop_slot(input int i);
      logic [EW-1:0] e;
      n_cmp++;
      if ((i == 0 && exp_q0.size() == 0) || (i == 1 && exp_q1.size() == 0)) begin
         n_err++;
         $display("FAIL sb_empty%0d: got response, expected queue empty (t=%0t)", i, $time);
      end else begin
         e = (i == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
         {m_res[i], m_zero[i], m_tag[i]} = e;
      end
   endtask

   task automatic check_outputs();
      chk("rsp_valid", 64'(rsp_valid_o), 64'(m_vld));
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("rsp_result%0d", i), 64'(rsp_result_o[i]), 64'(m_res[i]));
         chk($sformatf("rsp_zero%0d", i),   64'(rsp_zero_o[i]),   64'(m_zero[i]));
         chk($sformatf("rsp_tag%0d", i),    64'(rsp_tag_o[i]),    64'(m_tag[i]));
`ifdef RV_ALU_ARB_STATS_EN
         chk($sformatf("grant_cnt%0d", i), 64'(grant_cnt_o[i]), 64'(m_cnt[i]));
`else
         chk($sformatf("grant_cnt%0d", i), 64'(grant_cnt_o[i]), 64'd0);
`endif
      end
   endtask

   // ---------------- driver ----------------
   task automatic apply(input vec_t v);
      logic [31:0] r;
      n_vec++;
      req_valid_i  = v.valid;
      rsp_ready_i  = v.rready;
      req_op_i[0]  = v.op0; req_a_i[0] = v.a0; req_b_i[0] = v.b0; req_tag_i[0] = v.t0;
      req_op_i[1]  = v.op1; req_a_i[1] = v.a1; req_b_i[1] = v.b1; req_tag_i[1] = v.t1;
      @(negedge clk);
      chk("req_ready", 64'(req_ready_o), 64'(v.exp_grant));
      if (v.exp_grant == 2'b01) begin
         chk("alu_ctrl", 64'(alu_ctrl_o), 64'(v.op0));
         chk("alu_a", 64'(alu_operand_a_o), 64'(v.a0));
         chk("alu_b", 64'(alu_operand_b_o), 64'(v.b0));
         r = alu_f(v.op0, v.a0, v.b0);
         exp_q0.push_back({r, r == 32'd0, v.t0});
      end else if (v.exp_grant == 2'b10) begin
         chk("alu_ctrl", 64'(alu_ctrl_o), 64'(v.op1));
         chk("alu_a", 64'(alu_operand_a_o), 64'(v.a1));
         chk("alu_b", 64'(alu_operand_b_o), 64'(v.b1));
         r = alu_f(v.op1, v.a1, v.b1);
         exp_q1.push_back({r, r == 32'd0, v.t1});
      end else begin
         chk("idle_ctrl", 64'(alu_ctrl_o), 64'(OP_AND));
         chk("idle_a", 64'(alu_operand_a_o), 64'd0);
         chk("idle_b", 64'(alu_operand_b_o), 64'd0);
      end
      for (int i = 0; i < 2; i++) begin
         if (v.exp_grant[i]) begin
            m_vld[i] = 1'b1;
            if (m_cnt[i] != 16'hFFFF) m_cnt[i] = m_cnt[i] + 16'd1;
         end else if (v.rready[i]) begin
            m_vld[i] = 1'b0;
         end
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
         if (v.exp_grant[i]) pop_slot(i);
      end
      check_outputs();
   endtask

   task automatic do_reset();
      rst         = 1'b1;
      req_valid_i = 2'b11;
      rsp_ready_i = 2'b00;
      @(negedge clk);
      chk("ready_in_reset", 64'(req_ready_o), 64'd0);
      @(posedge clk);
      #1;
      rst         = 1'b0;
      req_valid_i = 2'b00;
      m_vld = '0; m_res = '0; m_zero = '0; m_tag = '0; m_cnt = '0;
      exp_q0.delete();
      exp_q1.delete();
      check_outputs();
   endtask

   // ---------------- test ----------------
   vec_t tbl[$];

   initial begin
      rst = 1'b1;
      req_valid_i = '0; rsp_ready_i = '0;
      req_op_i[0] = OP_AND; req_op_i[1] = OP_AND;
      req_a_i = '0; req_b_i = '0; req_tag_i = '0;

      // single request, then idle with slot 0 held
      tbl.push_back(mk(2'b01, 2'b11, OP_ADD, 5, 7, 3, OP_AND, 0, 0, 0, 2'b01));
      tbl.push_back(mk(2'b00, 2'b00, OP_OR, 32'hFF, 1, 1, OP_OR, 2, 3, 2, 2'b00));
      // contention: pointer now favours requester 1
      for (int k = 0; k < 6; k++) begin
         tbl.push_back(mk(2'b11, 2'b11,
                          rand_op(), $urandom, $urandom, 4'(k),
                          rand_op(), $urandom, $urandom, 4'(k + 8),
                          (k % 2 == 0) ? 2'b10 : 2'b01));
      end
      // backpressure on slot 1
      tbl.push_back(mk(2'b10, 2'b11, OP_AND, 0, 0, 0, OP_SUB, 9, 9, 5, 2'b10));
      for (int k = 0; k < 4; k++) begin
         tbl.push_back(mk(2'b10, 2'b01, OP_AND, 0, 0, 0, OP_ADD, 1, 2, 6, 2'b00));
      end
      tbl.push_back(mk(2'b10, 2'b11, OP_AND, 0, 0, 0, OP_ADD, 1, 2, 6, 2'b10));
      // both slots full and not draining
      tbl.push_back(mk(2'b01, 2'b00, OP_XOR, 32'hA5A5_0000, 32'h0000_5A5A, 7, OP_AND, 0, 0, 0, 2'b01));
      tbl.push_back(mk(2'b11, 2'b00, OP_SRA, 32'h8000_0000, 4, 1, OP_SLT, 32'hFFFF_FFFF, 1, 2, 2'b00));
      tbl.push_back(mk(2'b11, 2'b01, OP_SRA, 32'h8000_0000, 4, 1, OP_SLT, 32'hFFFF_FFFF, 1, 2, 2'b01));
      tbl.push_back(mk(2'b11, 2'b11, OP_SLL, 1, 31, 9, OP_SLTU, 32'hFFFF_FFFF, 1, 10, 2'b10));
      tbl.push_back(mk(2'b01, 2'b00, OP_SUB, 3, 5, 11, OP_AND, 0, 0, 0, 2'b01));

      do_reset();
      foreach (tbl[k]) apply(tbl[k]);

      // reset while both slots hold results; first grant afterwards goes to 0
      do_reset();
      apply(mk(2'b11, 2'b11, OP_ADD, 100, 200, 12, OP_SUB, 50, 8, 13, 2'b01));
      apply(mk(2'b11, 2'b11, OP_OR, 0, 0, 14, OP_SRL, 32'h8000_0000, 31, 15, 2'b10));

`ifdef RV_ALU_ARB_STATS_EN
      for (int k = 0; k < 70000; k++) begin
         apply(mk(2'b01, 2'b11, OP_ADD, 32'(k), 1, 4'(k), OP_AND, 0, 0, 0, 2'b01));
      end
      chk("grant_cnt0_sat", 64'(grant_cnt_o[0]), 64'h0000_0000_0000_FFFF);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
